agu_rs: RTL and testbench
=========================

Name: agu_rs

Overview:
- Reservation station plus address-generation stage for memory uops, directly upstream of the load/store queue.
- Holds dispatched load/store uops until their source physical registers are produced, as seen by CDB wakeup.
- Selects the oldest ready uop, reads the PRF, and computes address, byte mask and store data.
- Delivers one result per cycle to the LSQ, which matches the result to its pre-allocated entry by rob_id.

Parameters:
- AGU_RS_DEPTH, 4, number of station entries.
- ROB_IDX, 5, ROB index width.
- PRF_IDX, 6, physical register index width.
- CDB_PORTS, 3, number of CDB broadcast ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ds_valid  in  1  dispatch offers a memory uop
- ds_ready  out  1  station can accept this cycle
- ds_rob_id  in  ROB_IDX  ROB index of uop
- ds_fu_opcode  in  4  LB=0000 LH=0001 LW=0010 LBU=0100 LHU=0101 SB=1000 SH=1001 SW=1010; bit3=store
- ds_rs1_phy / ds_rs2_phy  in  PRF_IDX  source physical regs
- ds_rs1_ready / ds_rs2_ready  in  1  source already available at dispatch
- ds_imm  in  32  sign-extended offset
- cdb_valid  in  CDB_PORTS  broadcast valid per port
- cdb_rd_phy  in  CDB_PORTS*PRF_IDX  broadcast dest phys reg per port
- prf_rs1_phy / prf_rs2_phy  out  PRF_IDX  PRF read addresses (combinational read)
- prf_rs1_value / prf_rs2_value  in  32  PRF read data, same cycle
- agu_valid  out  1  result valid to LSQ
- agu_rob_id  out  ROB_IDX  rob_id of result
- agu_addr  out  32  unaligned effective address rs1+imm
- agu_mask  out  4  byte mask
- agu_wdata  out  32  lane-aligned store data, 0 for loads
- agu_rs1_value_dbg / agu_rs2_value_dbg  out  32  operand values for RVFI; rs2 is 0 for loads

Behaviour:
- Reset state:
  - All entries invalid; agu_valid=0; agu_* data=0 in the first cycle after reset.
  - ds_ready=1 once reset deasserts.
- Reset mid-operation: every held uop and any in-flight result is discarded; no agu_valid follows.
- Entry fields: valid, rob_id, opcode, rs1_phy, rs1_rdy, rs2_phy, rs2_rdy, imm, age.
- Loads: rs2_rdy is forced 1 at dispatch.
- Dispatch:
  - Accept on ds_valid&&ds_ready into the lowest-index free entry.
  - ds_ready = at least one entry invalid at cycle start. An entry freed by issue in the same cycle does not count.
- Wakeup:
  - Any cdb_valid[k] with cdb_rd_phy[k]==entry source sets that rdy bit at the clock edge.
  - This also applies to the uop being dispatched that cycle: ds_rsX_ready=0 with a same-cycle CDB match is captured as ready.
  - A woken entry is issuable the next cycle; no same-cycle bypass from CDB to select.
- Select:
  - Candidates are valid entries with rs1_rdy&&rs2_rdy; choose the oldest by dispatch order (age counter or age matrix).
  - At most one issue per cycle. The issued entry becomes invalid at that clock edge.
  - prf_rsX_phy are driven from the selected entry; they are don't-care when nothing issues.
- AGU stage: one pipeline register; a uop selected in cycle N gives agu_valid=1 in cycle N+1 only. The LSQ has no backpressure.
- Address: addr = rs1 + imm, mod 2^32, passed unaligned.
- Mask, o = addr[1:0]:
  - LB/LBU/SB: 0001<<o.
  - LH/LHU/SH: 0011<<o.
  - LW/SW: 1111.
- Misaligned halfword/word accesses are unsupported; the output for them is unspecified.
- Store data:
  - SB: rs2[7:0]<<8*o.
  - SH: rs2[15:0]<<16*addr[1].
  - SW: rs2.
- Full station: ds_ready=0 even if an issue happens that cycle; the uop is accepted the next cycle.
- Wrap-around: the age ordering must stay correct across arbitrary refill order; entry index does not imply age.
- No flush input.

Test Plan:
- Reset, then dispatch LW rob=3, rs1 ready, PRF rs1=0x1000, imm=0x8 -> next cycle issue; the cycle after, agu_valid=1, addr=0x1008, mask=1111, wdata=0.
- Dispatch SB rob=5, rs1 ready=0x2003, rs2 not ready phy=9; CDB phy=9 two cycles later with PRF rs2=0xAB -> issue the cycle after the CDB; result mask=1000, wdata=0xAB000000, rs2_dbg=0xAB.
- Dispatch LH with rs1 not ready, in the same cycle as a CDB match on rs1 -> captured ready; issues the following cycle, agu_valid two cycles after dispatch.
- Fill 4 entries with rs1 not ready (rob 1..4); wake all with one CDB -> four consecutive agu_valid in rob order 1,2,3,4; ds_ready=0 while full, 1 after the first issue edge.
- Free the middle entry, then dispatch a new uop (rob 7) into it while older rob 2 is still waiting; wake both together -> rob 2 is output before rob 7.
- Assert rst with two entries valid and one result in flight -> agu_valid=0 from the next cycle onward, ds_ready=1, no stale results after reset.

Source files
------------

// File: rtl/agu_rs.sv
// Memory-uop reservation station with CDB wakeup, oldest-ready select and a
// single registered address-generation stage feeding the load/store queue.
module agu_rs #(
    parameter int AGU_RS_DEPTH = 4,
    parameter int ROB_IDX      = 5,
    parameter int PRF_IDX      = 6,
    parameter int CDB_PORTS    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ds_valid,
    output logic                          ds_ready,
    input  logic [ROB_IDX-1:0]            ds_rob_id,
    input  logic [3:0]                    ds_fu_opcode,
    input  logic [PRF_IDX-1:0]            ds_rs1_phy,
    input  logic [PRF_IDX-1:0]            ds_rs2_phy,
    input  logic                          ds_rs1_ready,
    input  logic                          ds_rs2_ready,
    input  logic [31:0]                   ds_imm,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*PRF_IDX-1:0]  cdb_rd_phy,
    output logic [PRF_IDX-1:0]            prf_rs1_phy,
    output logic [PRF_IDX-1:0]            prf_rs2_phy,
    input  logic [31:0]                   prf_rs1_value,
    input  logic [31:0]                   prf_rs2_value,
    output logic                          agu_valid,
    output logic [ROB_IDX-1:0]            agu_rob_id,
    output logic [31:0]                   agu_addr,
    output logic [3:0]                    agu_mask,
    output logic [31:0]                   agu_wdata,
    output logic [31:0]                   agu_rs1_value_dbg,
    output logic [31:0]                   agu_rs2_value_dbg
);
    localparam int IDX_W = (AGU_RS_DEPTH > 1) ? $clog2(AGU_RS_DEPTH) : 1;

    logic [AGU_RS_DEPTH-1:0] r_valid;
    logic [AGU_RS_DEPTH-1:0] r_rs1_rdy;
    logic [AGU_RS_DEPTH-1:0] r_rs2_rdy;
    logic [ROB_IDX-1:0]      r_rob_id  [AGU_RS_DEPTH];
    logic [3:0]              r_opcode  [AGU_RS_DEPTH];
    logic [PRF_IDX-1:0]      r_rs1_phy [AGU_RS_DEPTH];
    logic [PRF_IDX-1:0]      r_rs2_phy [AGU_RS_DEPTH];
    logic [31:0]             r_imm     [AGU_RS_DEPTH];
    // r_older[i][j] set means entry i was dispatched before entry j
    logic [AGU_RS_DEPTH-1:0] r_older   [AGU_RS_DEPTH];

    logic                    r_agu_valid;
    logic [ROB_IDX-1:0]      r_agu_rob_id;
    logic [31:0]             r_agu_addr;
    logic [3:0]              r_agu_mask;
    logic [31:0]             r_agu_wdata;
    logic [31:0]             r_agu_rs1_dbg;
    logic [31:0]             r_agu_rs2_dbg;

    logic [AGU_RS_DEPTH-1:0] w_wake1;
    logic [AGU_RS_DEPTH-1:0] w_wake2;
    logic                    w_ds_wake1;
    logic                    w_ds_wake2;
    logic [AGU_RS_DEPTH-1:0] w_cand;
    logic                    w_issue;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [IDX_W-1:0]        w_alloc_idx;
    logic                    w_accept;
    logic [3:0]              w_op;
    logic                    w_store;
    logic [31:0]             w_addr;
    logic [3:0]              w_mask;
    logic [31:0]             w_wdata;

    always_comb begin
        w_wake1    = '0;
        w_wake2    = '0;
        w_ds_wake1 = 1'b0;
        w_ds_wake2 = 1'b0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < AGU_RS_DEPTH; i++) begin
                    if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == r_rs1_phy[i]) w_wake1[i] = 1'b1;
                    if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == r_rs2_phy[i]) w_wake2[i] = 1'b1;
                end
                if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == ds_rs1_phy) w_ds_wake1 = 1'b1;
                if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == ds_rs2_phy) w_ds_wake2 = 1'b1;
            end
        end
    end

    assign w_cand = r_valid & r_rs1_rdy & r_rs2_rdy;

    always_comb begin
        logic w_oldest;
        w_issue   = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < AGU_RS_DEPTH; i++) begin
            w_oldest = w_cand[i];
            for (int j = 0; j < AGU_RS_DEPTH; j++) begin
                if (j != i && w_cand[j] && r_older[j][i]) w_oldest = 1'b0;
            end
            if (w_oldest) begin
                w_issue   = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_alloc_idx = '0;
        for (int i = AGU_RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_alloc_idx = IDX_W'(i);
        end
    end

    // Readiness reflects occupancy at cycle start; a same-cycle issue does not free a slot.
    assign ds_ready = ~&r_valid;
    assign w_accept = ds_valid & ds_ready;

    assign prf_rs1_phy = r_rs1_phy[w_sel_idx];
    assign prf_rs2_phy = r_rs2_phy[w_sel_idx];
    assign w_op        = r_opcode[w_sel_idx];
    assign w_store     = w_op[3];
    assign w_addr      = prf_rs1_value + r_imm[w_sel_idx];

    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = prf_rs2_value;
        case (w_op)
            4'b0000, 4'b0100, 4'b1000: begin
                w_mask  = 4'b0001 << w_addr[1:0];
                w_wdata = {24'b0, prf_rs2_value[7:0]} << {w_addr[1:0], 3'b000};
            end
            4'b0001, 4'b0101, 4'b1001: begin
                w_mask  = 4'b0011 << w_addr[1:0];
                w_wdata = {16'b0, prf_rs2_value[15:0]} << {w_addr[1], 4'b0000};
            end
            default: ;
        endcase
        if (!w_store) w_wdata = '0;
    end

    // NOTE: only valid bits and the result stage are reset; payload is qualified by valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rob_id[w_alloc_idx]  <= ds_rob_id;
            r_opcode[w_alloc_idx]  <= ds_fu_opcode;
            r_rs1_phy[w_alloc_idx] <= ds_rs1_phy;
            r_rs2_phy[w_alloc_idx] <= ds_rs2_phy;
            r_imm[w_alloc_idx]     <= ds_imm;
        end
        for (int i = 0; i < AGU_RS_DEPTH; i++) begin
            if (w_wake1[i]) r_rs1_rdy[i] <= 1'b1;
            if (w_wake2[i]) r_rs2_rdy[i] <= 1'b1;
        end
        if (w_accept) begin
            r_rs1_rdy[w_alloc_idx] <= ds_rs1_ready | w_ds_wake1;
            r_rs2_rdy[w_alloc_idx] <= ~ds_fu_opcode[3] | ds_rs2_ready | w_ds_wake2;
            r_older[w_alloc_idx]   <= '0;
            for (int j = 0; j < AGU_RS_DEPTH; j++) begin
                r_older[j][w_alloc_idx] <= (j != int'(w_alloc_idx));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_agu_valid   <= 1'b0;
            r_agu_rob_id  <= '0;
            r_agu_addr    <= '0;
            r_agu_mask    <= '0;
            r_agu_wdata   <= '0;
            r_agu_rs1_dbg <= '0;
            r_agu_rs2_dbg <= '0;
        end else begin
            if (w_issue)  r_valid[w_sel_idx]   <= 1'b0;
            if (w_accept) r_valid[w_alloc_idx] <= 1'b1;
            r_agu_valid <= w_issue;
            if (w_issue) begin
                r_agu_rob_id  <= r_rob_id[w_sel_idx];
                r_agu_addr    <= w_addr;
                r_agu_mask    <= w_mask;
                r_agu_wdata   <= w_wdata;
                r_agu_rs1_dbg <= prf_rs1_value;
                r_agu_rs2_dbg <= w_store ? prf_rs2_value : 32'h0;
            end
        end
    end

    assign agu_valid         = r_agu_valid;
    assign agu_rob_id        = r_agu_rob_id;
    assign agu_addr          = r_agu_addr;
    assign agu_mask          = r_agu_mask;
    assign agu_wdata         = r_agu_wdata;
    assign agu_rs1_value_dbg = r_agu_rs1_dbg;
    assign agu_rs2_value_dbg = r_agu_rs2_dbg;

endmodule

// File: tb/tb_agu_rs.sv
// Self-checking bench for agu_rs: directed scenarios plus random traffic, all
// compared against a sequence-numbered behavioural model of the station.
module tb_agu_rs;
    localparam int D  = 4;
    localparam int RB = 5;
    localparam int PB = 6;
    localparam int CP = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             ds_valid;
    logic             ds_ready;
    logic [RB-1:0]    ds_rob_id;
    logic [3:0]       ds_fu_opcode;
    logic [PB-1:0]    ds_rs1_phy, ds_rs2_phy;
    logic             ds_rs1_ready, ds_rs2_ready;
    logic [31:0]      ds_imm;
    logic [CP-1:0]    cdb_valid;
    logic [CP*PB-1:0] cdb_rd_phy;
    logic [PB-1:0]    prf_rs1_phy, prf_rs2_phy;
    logic [31:0]      prf_rs1_value, prf_rs2_value;
    logic             agu_valid;
    logic [RB-1:0]    agu_rob_id;
    logic [31:0]      agu_addr;
    logic [3:0]       agu_mask;
    logic [31:0]      agu_wdata;
    logic [31:0]      agu_rs1_value_dbg, agu_rs2_value_dbg;

    logic [31:0] prf_mem [64];

    assign prf_rs1_value = prf_mem[prf_rs1_phy];
    assign prf_rs2_value = prf_mem[prf_rs2_phy];

    always #5 clk = ~clk;

    agu_rs #(.AGU_RS_DEPTH(D), .ROB_IDX(RB), .PRF_IDX(PB), .CDB_PORTS(CP)) dut (
        .clk(clk), .rst(rst),
        .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_rob_id(ds_rob_id),
        .ds_fu_opcode(ds_fu_opcode), .ds_rs1_phy(ds_rs1_phy), .ds_rs2_phy(ds_rs2_phy),
        .ds_rs1_ready(ds_rs1_ready), .ds_rs2_ready(ds_rs2_ready), .ds_imm(ds_imm),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
        .prf_rs1_phy(prf_rs1_phy), .prf_rs2_phy(prf_rs2_phy),
        .prf_rs1_value(prf_rs1_value), .prf_rs2_value(prf_rs2_value),
        .agu_valid(agu_valid), .agu_rob_id(agu_rob_id), .agu_addr(agu_addr),
        .agu_mask(agu_mask), .agu_wdata(agu_wdata),
        .agu_rs1_value_dbg(agu_rs1_value_dbg), .agu_rs2_value_dbg(agu_rs2_value_dbg)
    );

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                           LHU = 4'b0101, SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

    typedef struct {
        bit          v;
        bit [RB-1:0] rob;
        bit [3:0]    op;
        bit [PB-1:0] p1;
        bit          r1;
        bit [PB-1:0] p2;
        bit          r2;
        bit [31:0]   imm;
        int unsigned seq;
    } ent_t;

    ent_t        m [D];
    int unsigned m_seq;
    bit          exp_valid, exp_aligned, zero_chk;
    bit [RB-1:0] exp_rob;
    bit [31:0]   exp_addr, exp_wdata, exp_rs1, exp_rs2;
    bit [3:0]    exp_mask;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cdb_hits(input bit [PB-1:0] phy);
        for (int k = 0; k < CP; k++)
            if (cdb_valid[k] && cdb_rd_phy[k*PB +: PB] == phy) return 1'b1;
        return 1'b0;
    endfunction

    // Model one clock edge from current state and the inputs now on the pins.
    task automatic model_step();
        int sel, free_slot, size;
        bit [31:0] a, rs2;
        bit [1:0]  o;
        if (rst) begin
            for (int i = 0; i < D; i++) m[i].v = 1'b0;
            exp_valid = 1'b0;
            zero_chk  = 1'b1;
            return;
        end
        zero_chk = 1'b0;
        sel = -1;
        free_slot = -1;
        for (int i = 0; i < D; i++)
            if (m[i].v && m[i].r1 && m[i].r2 && (sel < 0 || m[i].seq < m[sel].seq)) sel = i;
        for (int i = D - 1; i >= 0; i--)
            if (!m[i].v) free_slot = i;
        exp_valid = (sel >= 0);
        if (sel >= 0) begin
            a    = prf_mem[m[sel].p1] + m[sel].imm;
            o    = a[1:0];
            rs2  = m[sel].op[3] ? prf_mem[m[sel].p2] : 32'h0;
            size = (m[sel].op[1:0] == 2'b00) ? 1 : (m[sel].op[1:0] == 2'b01) ? 2 : 4;
            exp_rob     = m[sel].rob;
            exp_addr    = a;
            exp_rs1     = prf_mem[m[sel].p1];
            exp_rs2     = rs2;
            exp_aligned = (int'(o) % size) == 0;
            exp_mask    = '0;
            exp_wdata   = '0;
            for (int b = 0; b < size; b++) begin
                if (int'(o) + b < 4) begin
                    exp_mask[int'(o) + b] = 1'b1;
                    exp_wdata[(int'(o) + b) * 8 +: 8] = rs2[b * 8 +: 8];
                end
            end
            m[sel].v = 1'b0;
        end
        if (ds_valid && free_slot >= 0) begin
            m[free_slot] = '{v: 1'b1, rob: ds_rob_id, op: ds_fu_opcode, p1: ds_rs1_phy,
                             r1: ds_rs1_ready, p2: ds_rs2_phy,
                             r2: (!ds_fu_opcode[3]) || ds_rs2_ready, imm: ds_imm, seq: m_seq};
            m_seq++;
        end
        for (int i = 0; i < D; i++) begin
            if (m[i].v && cdb_hits(m[i].p1)) m[i].r1 = 1'b1;
            if (m[i].v && cdb_hits(m[i].p2)) m[i].r2 = 1'b1;
        end
    endtask

    task automatic step();
        bit exp_ready;
        exp_ready = 1'b0;
        for (int i = 0; i < D; i++) if (!m[i].v) exp_ready = 1'b1;
        if (!rst) check("ds_ready", 32'(ds_ready), 32'(exp_ready));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("agu_valid", 32'(agu_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("agu_rob_id", 32'(agu_rob_id), 32'(exp_rob));
            check("agu_addr", agu_addr, exp_addr);
            check("rs1_dbg", agu_rs1_value_dbg, exp_rs1);
            check("rs2_dbg", agu_rs2_value_dbg, exp_rs2);
            if (exp_aligned) begin
                check("agu_mask", 32'(agu_mask), 32'(exp_mask));
                check("agu_wdata", agu_wdata, exp_wdata);
            end
        end else if (zero_chk) begin
            check("rst_rob_id", 32'(agu_rob_id), 32'h0);
            check("rst_addr", agu_addr, 32'h0);
            check("rst_mask", 32'(agu_mask), 32'h0);
            check("rst_wdata", agu_wdata, 32'h0);
        end
    endtask

    task automatic idle();
        ds_valid  = 1'b0;
        cdb_valid = '0;
    endtask

    task automatic dispatch(input bit [RB-1:0] rob, input bit [3:0] op,
                            input bit [PB-1:0] p1, input bit r1,
                            input bit [PB-1:0] p2, input bit r2, input bit [31:0] imm);
        ds_valid     = 1'b1;
        ds_rob_id    = rob;
        ds_fu_opcode = op;
        ds_rs1_phy   = p1;
        ds_rs1_ready = r1;
        ds_rs2_phy   = p2;
        ds_rs2_ready = r2;
        ds_imm       = imm;
    endtask

    task automatic cdb(input int port, input bit [PB-1:0] phy);
        cdb_valid[port] = 1'b1;
        cdb_rd_phy[port*PB +: PB] = phy;
    endtask

    localparam logic [3:0] OPS [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    initial begin
        for (int i = 0; i < 64; i++) prf_mem[i] = 32'h0;
        for (int i = 0; i < D; i++) m[i].v = 1'b0;
        m_seq = 0;
        rst = 1'b1;
        cdb_rd_phy = '0;
        idle();
        dispatch(0, LB, 0, 0, 0, 0, 0);
        ds_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("ds_ready_after_rst", 32'(ds_ready), 32'h1);

        // Ready LW issues next cycle, result the cycle after
        prf_mem[1] = 32'h1000;
        dispatch(3, LW, 1, 1, 0, 0, 32'h8);
        step();
        check("t1_not_yet", 32'(agu_valid), 32'h0);
        idle();
        step();
        check("t1_valid", 32'(agu_valid), 32'h1);
        check("t1_addr", agu_addr, 32'h1008);
        check("t1_mask", 32'(agu_mask), 32'hf);
        check("t1_wdata", agu_wdata, 32'h0);

        // SB waits for rs2 via CDB
        prf_mem[2] = 32'h2003;
        prf_mem[9] = 32'hAB;
        dispatch(5, SB, 2, 1, 9, 0, 0);
        step();
        idle();
        step();
        cdb(1, 9);
        step();
        idle();
        step();
        check("t2_valid", 32'(agu_valid), 32'h1);
        check("t2_mask", 32'(agu_mask), 32'h8);
        check("t2_wdata", agu_wdata, 32'hAB000000);
        check("t2_rs2_dbg", agu_rs2_value_dbg, 32'hAB);

        // Same-cycle CDB match at dispatch
        prf_mem[4] = 32'h3002;
        dispatch(6, LH, 4, 0, 0, 0, 0);
        cdb(2, 4);
        step();
        idle();
        step();
        check("t3_valid", 32'(agu_valid), 32'h1);
        check("t3_rob", 32'(agu_rob_id), 32'h6);
        check("t3_mask", 32'(agu_mask), 32'hc);

        // Fill, wake all at once, drain in dispatch order
        prf_mem[10] = 32'h4000;
        for (int n = 1; n <= 4; n++) begin
            dispatch(RB'(n), LW, 10, 0, 0, 0, 32'(n * 4));
            step();
        end
        idle();
        check("t4_full", 32'(ds_ready), 32'h0);
        cdb(0, 10);
        step();
        idle();
        dispatch(12, LW, 1, 1, 0, 0, 0);
        step();
        check("t4_order_1", 32'(agu_rob_id), 32'h1);
        step();
        check("t4_order_2", 32'(agu_rob_id), 32'h2);
        idle();
        step();
        check("t4_order_3", 32'(agu_rob_id), 32'h3);
        step();
        check("t4_order_4", 32'(agu_rob_id), 32'h4);
        step();
        check("t4_order_12", 32'(agu_rob_id), 32'hc);

        // Refill a freed middle slot with a younger uop
        prf_mem[20] = 32'h5000;
        prf_mem[21] = 32'h6000;
        prf_mem[22] = 32'h7000;
        dispatch(1, LW, 20, 0, 0, 0, 0);
        step();
        dispatch(8, LW, 22, 0, 0, 0, 0);
        step();
        dispatch(2, LW, 21, 0, 0, 0, 0);
        step();
        idle();
        cdb(0, 22);
        step();
        idle();
        step();
        check("t5_rob8", 32'(agu_rob_id), 32'h8);
        dispatch(7, LW, 21, 0, 0, 0, 32'h4);
        step();
        idle();
        cdb(1, 21);
        step();
        idle();
        step();
        check("t5_first", 32'(agu_rob_id), 32'h2);
        step();
        check("t5_second", 32'(agu_rob_id), 32'h7);
        cdb(0, 20);
        step();
        idle();
        step();
        check("t5_last", 32'(agu_rob_id), 32'h1);

        // Reset with held uops and a result in flight
        prf_mem[30] = 32'h8000;
        dispatch(9, LW, 30, 0, 0, 0, 0);
        step();
        dispatch(10, SW, 30, 0, 30, 0, 0);
        step();
        dispatch(11, LW, 1, 1, 0, 0, 0);
        step();
        idle();
        step();
        check("t6_inflight", 32'(agu_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_ready", 32'(ds_ready), 32'h1);
        cdb(0, 30);
        step();
        idle();
        for (int n = 0; n < 4; n++) begin
            step();
            check("t6_no_stale", 32'(agu_valid), 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 16; i++) prf_mem[i] = $urandom;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 299) == 0);
            ds_valid  = ($urandom_range(0, 9) < 6);
            ds_rob_id = RB'($urandom);
            ds_fu_opcode = OPS[$urandom_range(0, 7)];
            ds_rs1_phy   = PB'($urandom_range(0, 15));
            ds_rs2_phy   = PB'($urandom_range(0, 15));
            ds_rs1_ready = $urandom_range(0, 1) == 1;
            ds_rs2_ready = $urandom_range(0, 1) == 1;
            ds_imm       = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            for (int k = 0; k < CP; k++) begin
                cdb_valid[k] = ($urandom_range(0, 2) == 0);
                cdb_rd_phy[k*PB +: PB] = PB'($urandom_range(0, 15));
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
